// File: rtl/noc_packet_depacketizer_pkg.sv
// Shared NoC constants for the local-port depacketizer: flit field layout,
// framing markers, status error bit indices and FSM state encodings.
package noc_packet_depacketizer_pkg;

  localparam int unsigned NOC_DATA_W     = 32;
  localparam int unsigned NOC_ID_X_W     = 4;
  localparam int unsigned NOC_ID_Y_W     = 4;
  localparam int unsigned NOC_AXI_TYPE_W = 2;
  localparam int unsigned NOC_AXI_LEN_W  = 8;

  // Framing markers: H field is flit[NOC_DATA_W-1:NOC_POINT_H], E field is flit[NOC_POINT_E:0]
  localparam int unsigned NOC_POINT_H  = 30;
  localparam int unsigned NOC_POINT_E  = 1;
  localparam int unsigned NOC_MARK_H_W = NOC_DATA_W - NOC_POINT_H;
  localparam int unsigned NOC_MARK_E_W = NOC_POINT_E + 1;

  localparam logic [NOC_MARK_H_W-1:0] NOC_HEAD_H = NOC_MARK_H_W'(2'b10);
  localparam logic [NOC_MARK_E_W-1:0] NOC_HEAD_E = NOC_MARK_E_W'(2'b01);
  localparam logic [NOC_MARK_H_W-1:0] NOC_TAIL_H = NOC_MARK_H_W'(2'b11);
  localparam logic [NOC_MARK_E_W-1:0] NOC_TAIL_E = NOC_MARK_E_W'(2'b10);

  // Header field LSB positions
  localparam int unsigned NOC_SRC_X_LSB = 26;
  localparam int unsigned NOC_SRC_Y_LSB = 22;
  localparam int unsigned NOC_DST_X_LSB = 18;
  localparam int unsigned NOC_DST_Y_LSB = 14;
  localparam int unsigned NOC_TYPE_LSB  = 12;
  localparam int unsigned NOC_LEN_LSB   = 4;

  // pkt_err bit indices
  localparam int unsigned PKT_ERR_W        = 3;
  localparam int unsigned PKT_ERR_MISROUTE = 0;
  localparam int unsigned PKT_ERR_LEN      = 1;
  localparam int unsigned PKT_ERR_TAIL     = 2;

  typedef enum logic [1:0] {
    S_HEAD = 2'd0,
    S_DATA = 2'd1,
    S_TAIL = 2'd2
  } state_t;

  // Payload FIFO entry
  typedef struct packed {
    logic                  last;
    logic [NOC_DATA_W-1:0] data;
  } payload_t;

  function automatic logic head_check(input logic is_hdr, input logic [NOC_DATA_W-1:0] f);
    return is_hdr && (f[NOC_DATA_W-1:NOC_POINT_H] == NOC_HEAD_H) && (f[NOC_POINT_E:0] == NOC_HEAD_E);
  endfunction

  function automatic logic tail_check(input logic is_tail, input logic [NOC_DATA_W-1:0] f);
    return is_tail && (f[NOC_DATA_W-1:NOC_POINT_H] == NOC_TAIL_H) && (f[NOC_POINT_E:0] == NOC_TAIL_E);
  endfunction

endpackage

// File: rtl/noc_sync_fifo.sv
// Single-clock registered FIFO with wrap-bit pointers.
// Ports: i_clk/i_rst_n clock and async active-low reset; i_push/i_data write side
// (ignored when full); o_full; i_pop/o_valid/o_data first-word-fall-through read side.
module noc_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_full,
  input  logic             i_pop,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_empty;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  // Full: same index, opposite wrap bit
  assign o_full    = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~w_empty;
  assign o_valid   = ~w_empty;
  assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/noc_packet_depacketizer.sv
// Ejection-side depacketizer: validates header/tail framing and destination,
// strips header and tail, streams payload through a FIFO and reports one
// status record per packet.
// Ports: noc_clk/noc_rst_n; in_* flit input from router local port;
// out_* payload stream; pkt_* per-packet status (pkt_done pulse); drop_cnt.
module noc_packet_depacketizer
  import noc_packet_depacketizer_pkg::*;
#(
  parameter logic [NOC_ID_X_W-1:0] X_ID       = '0,
  parameter logic [NOC_ID_Y_W-1:0] Y_ID       = '0,
  parameter int unsigned           FIFO_DEPTH = 4,
  parameter int unsigned           CNT_W      = 16
) (
  input  logic                      noc_clk,
  input  logic                      noc_rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NOC_DATA_W-1:0]     in_flit,
  input  logic                      in_is_header,
  input  logic                      in_is_tail,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NOC_DATA_W-1:0]     out_data,
  output logic                      out_last,
  output logic                      pkt_done,
  output logic [NOC_ID_X_W-1:0]     pkt_src_x,
  output logic [NOC_ID_Y_W-1:0]     pkt_src_y,
  output logic [NOC_AXI_TYPE_W-1:0] pkt_type,
  output logic [NOC_AXI_LEN_W-1:0]  pkt_len,
  output logic [PKT_ERR_W-1:0]      pkt_err,
  output logic [CNT_W-1:0]          drop_cnt
);

  state_t                    r_state;
  logic [NOC_ID_X_W-1:0]     r_src_x;
  logic [NOC_ID_Y_W-1:0]     r_src_y;
  logic [NOC_AXI_TYPE_W-1:0] r_type;
  logic [NOC_AXI_LEN_W-1:0]  r_len_exp;
  logic [NOC_AXI_LEN_W-1:0]  r_cnt;
  logic [PKT_ERR_W-1:0]      r_err;

  logic                      w_acc;
  logic                      w_head_ok;
  logic                      w_tail_ok;
  logic                      w_push;
  logic                      w_last;
  logic                      w_misroute;
  logic                      w_drop;
  logic                      w_fin;
  logic [PKT_ERR_W-1:0]      w_err_fin;
  logic                      w_fifo_full;
  logic                      w_fifo_valid;
  payload_t                  w_push_entry;
  payload_t                  w_head_entry;
  logic [NOC_AXI_LEN_W-1:0]  w_hdr_len;

  // Ready depends only on state and the registered FIFO full flag
  assign in_ready   = (r_state == S_DATA) ? ~w_fifo_full : 1'b1;
  assign w_acc      = in_valid & in_ready;
  assign w_head_ok  = head_check(in_is_header, in_flit);
  assign w_tail_ok  = tail_check(in_is_tail, in_flit);
  assign w_hdr_len  = in_flit[NOC_LEN_LSB +: NOC_AXI_LEN_W];
  assign w_misroute = (in_flit[NOC_DST_X_LSB +: NOC_ID_X_W] != X_ID) ||
                      (in_flit[NOC_DST_Y_LSB +: NOC_ID_Y_W] != Y_ID);
  assign w_push     = w_acc && (r_state == S_DATA) && !in_is_tail;
  assign w_last     = (NOC_AXI_LEN_W'(r_cnt + 1'b1) == r_len_exp);
  assign w_drop     = w_acc && (((r_state == S_HEAD) && !w_head_ok) ||
                                ((r_state == S_TAIL) && !in_is_header && !in_is_tail));

  assign w_push_entry.last = w_last;
  assign w_push_entry.data = in_flit;

  // Packet completion and its final error vector
  always_comb begin
    w_fin     = 1'b0;
    w_err_fin = r_err;
    if (w_acc) begin
      case (r_state)
        S_DATA: if (in_is_tail) begin
          w_fin                   = 1'b1;
          w_err_fin[PKT_ERR_LEN]  = 1'b1;
          w_err_fin[PKT_ERR_TAIL] = ~w_tail_ok;
        end
        S_TAIL: if (in_is_header) begin
          // A header here closes the packet as a malformed tail and is consumed
          w_fin                   = 1'b1;
          w_err_fin[PKT_ERR_LEN]  = 1'b1;
          w_err_fin[PKT_ERR_TAIL] = 1'b1;
        end else if (in_is_tail) begin
          w_fin                   = 1'b1;
          w_err_fin[PKT_ERR_TAIL] = ~w_tail_ok;
        end
        default: ;
      endcase
    end
  end

  // Framing FSM, packet context and status registers
  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      r_state   <= S_HEAD;
      r_src_x   <= '0;
      r_src_y   <= '0;
      r_type    <= '0;
      r_len_exp <= '0;
      r_cnt     <= '0;
      r_err     <= '0;
      pkt_done  <= 1'b0;
      pkt_src_x <= '0;
      pkt_src_y <= '0;
      pkt_type  <= '0;
      pkt_len   <= '0;
      pkt_err   <= '0;
      drop_cnt  <= '0;
    end else begin
      pkt_done <= 1'b0;
      if (w_drop && (drop_cnt != {CNT_W{1'b1}})) drop_cnt <= CNT_W'(drop_cnt + 1'b1);
      if (w_acc) begin
        case (r_state)
          S_HEAD: if (w_head_ok) begin
            r_src_x   <= in_flit[NOC_SRC_X_LSB +: NOC_ID_X_W];
            r_src_y   <= in_flit[NOC_SRC_Y_LSB +: NOC_ID_Y_W];
            r_type    <= in_flit[NOC_TYPE_LSB +: NOC_AXI_TYPE_W];
            r_len_exp <= w_hdr_len;
            r_cnt     <= '0;
            r_err     <= '0;
            r_err[PKT_ERR_MISROUTE] <= w_misroute;
            r_state   <= (w_hdr_len == '0) ? S_TAIL : S_DATA;
          end
          S_DATA: if (!in_is_tail) begin
            r_cnt <= NOC_AXI_LEN_W'(r_cnt + 1'b1);
            if (w_last) r_state <= S_TAIL;
          end
          S_TAIL: if (!in_is_header && !in_is_tail) r_err[PKT_ERR_LEN] <= 1'b1;
          default: r_state <= S_HEAD;
        endcase
      end
      if (w_fin) begin
        pkt_done  <= 1'b1;
        pkt_src_x <= r_src_x;
        pkt_src_y <= r_src_y;
        pkt_type  <= r_type;
        pkt_len   <= r_cnt;
        pkt_err   <= w_err_fin;
        r_state   <= S_HEAD;
      end
    end
  end

  noc_sync_fifo #(
    .WIDTH ($bits(payload_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (noc_clk),
    .i_rst_n (noc_rst_n),
    .i_push  (w_push),
    .i_data  (w_push_entry),
    .o_full  (w_fifo_full),
    .i_pop   (out_ready),
    .o_valid (w_fifo_valid),
    .o_data  (w_head_entry)
  );

  assign out_valid = w_fifo_valid;
  assign out_data  = w_head_entry.data;
  assign out_last  = w_head_entry.last & w_fifo_valid;

endmodule
